// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, funct3 encodings, FSM states and alignment helper for mem_stage
package mem_stage_pkg;

  localparam int XLEN_DEF = 64;
  localparam int ILEN_DEF = 32;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_D  = 3'b011,
    F3_BU = 3'b100,
    F3_HU = 3'b101,
    F3_WU = 3'b110
  } funct3_e;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } state_e;

  // funct3[1:0] encodes log2 of the access size for loads and stores alike
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] addr_lo);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return addr_lo[0];
      2'b10:   return |addr_lo[1:0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ls_align.sv
// rtl/mem_stage_ls_align.sv - combinational load extraction and store strobe/data lane placement
module ls_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      addr_lo,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs2data,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] load_data,
  output logic [7:0]      wstrb,
  output logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};
  assign wdata   = rs2data << {addr_lo, 3'b000};

  always_comb begin
    load_data = shifted;
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_WU:   load_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    wstrb = 8'h00;
    case (funct3[1:0])
      2'b00:   wstrb = 8'h01 << addr_lo;
      2'b01:   wstrb = 8'h03 << addr_lo;
      2'b10:   wstrb = 8'h0F << addr_lo;
      default: wstrb = 8'hFF << addr_lo;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage with load/store bus FSM; optional MEM_MISALIGN_CHECK_EN
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ILEN = ILEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic [ILEN-1:0] instr_i,
  input  logic [XLEN-1:0] alures_i,
  input  logic [XLEN-1:0] csrdata_i,
  input  logic [XLEN-1:0] rs2data_i,
  input  logic            in_valid_i,
  input  logic            is_load_i,
  input  logic            is_store_i,
  input  logic            wben_i,
  input  logic [2:0]      ls_funct3_i,
  output logic            stall_o,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [XLEN-1:0] mem_req_addr_o,
  output logic            mem_req_we_o,
  output logic [XLEN-1:0] mem_req_wdata_o,
  output logic [7:0]      mem_req_wstrb_o,
  input  logic            mem_rsp_valid_i,
  input  logic [XLEN-1:0] mem_rsp_rdata_i,
  output logic [XLEN-1:0] pc_o,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] alures_o,
  output logic [XLEN-1:0] lsres_o,
  output logic [XLEN-1:0] csrdata_o,
  output logic            wben_o,
  output logic            out_valid_o,
  output logic            misalign_o
);

  state_e          state;
  logic [XLEN-1:0] load_data;
  logic            bad_align;
  logic            stall_q;

  ls_align #(.XLEN(XLEN)) u_ls_align (
    .addr_lo   (alures_i[2:0]),
    .funct3    (ls_funct3_i),
    .rs2data   (rs2data_i),
    .rdata     (mem_rsp_rdata_i),
    .load_data (load_data),
    .wstrb     (mem_req_wstrb_o),
    .wdata     (mem_req_wdata_o)
  );

`ifdef MEM_MISALIGN_CHECK_EN
  assign bad_align = is_misaligned(ls_funct3_i, alures_i[2:0]);
`else
  assign bad_align = 1'b0;
`endif

  assign pc_o           = pc_i;
  assign instr_o        = instr_i;
  assign alures_o       = alures_i;
  assign csrdata_o      = csrdata_i;
  assign mem_req_addr_o = {alures_i[XLEN-1:3], 3'b000};
  assign mem_req_we_o   = is_store_i & ~is_load_i;
  assign wben_o         = wben_i & out_valid_o & ~misalign_o;

  // Outputs are combinational from state so non-memory ops and handshakes add no latency
  always_comb begin
    mem_req_valid_o = 1'b0;
    stall_o         = 1'b0;
    out_valid_o     = 1'b0;
    misalign_o      = 1'b0;
    lsres_o         = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            if (!(is_load_i || is_store_i)) begin
              out_valid_o = 1'b1;
            end else if (bad_align) begin
              out_valid_o = 1'b1;
              misalign_o  = 1'b1;
            end else begin
              mem_req_valid_o = 1'b1;
              if (is_load_i) begin
                stall_o = 1'b1;
              end else begin
                stall_o     = ~mem_req_ready_i;
                out_valid_o = mem_req_ready_i;
              end
            end
          end
        end
        WAIT_RSP: begin
          stall_o     = ~mem_rsp_valid_i;
          out_valid_o = mem_rsp_valid_i;
          if (mem_rsp_valid_i) lsres_o = load_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:     if (mem_req_valid_o && mem_req_ready_i && is_load_i) state <= WAIT_RSP;
        WAIT_RSP: if (mem_rsp_valid_i) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Upstream must keep the instruction presented for as long as it is stalled
  always_ff @(posedge clk) begin
    stall_q <= stall_o;
    if (!rst && stall_q) assert (in_valid_i);
  end

endmodule
